xbar_reg_nports: RTL and testbench

- Parametrised, registered successor to the fixed 6-port router crossbar.
- Connects NUM_PORT input channels to NUM_PORT output channels under a per-cycle allocation matrix from the switch allocator.
- Adds per-flit valid tracking, multicast (one input to several outputs), conflict detection, a global stall, and 1 or 2 pipeline stages.
- Sits between the router's switch allocator/input buffers and its output links; bypass port is ordinary port 0.

---
 rtl/xbar_reg_nports_pkg.sv | 21 ++
 rtl/xbar_onehot_sel.sv | 42 ++++
 rtl/xbar_reg_nports.sv | 119 +++++++++++
 tb/tb_xbar_reg_nports.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/xbar_reg_nports_pkg.sv
// Shared constants, parameter legality check and bus packing macros for the
// registered N-port router crossbar and its switch allocator.
`ifndef XBAR_REG_NPORTS_PKG_MACROS
`define XBAR_REG_NPORTS_PKG_MACROS
// Port-major packed buses: lane idx of a bus whose lanes are w bits wide.
`define XBAR_LANE(bus, idx, w) bus[(idx)*(w) +: (w)]
// Bit of the allocation matrix that routes inPort to outPort.
`define XBAR_ALLOC_BIT(outPort, inPort, n) ((outPort)*(n) + (inPort))
`endif

package xbar_reg_nports_pkg;

    localparam int DEF_NUM_PORT = 6;
    localparam int DEF_WIDTH    = 64;
    localparam int DEF_CNT_W    = 8;

    function automatic bit pipeDepthOk(input int depth);
        return (depth == 1) || (depth == 2);
    endfunction

endpackage

// File: rtl/xbar_onehot_sel.sv
// One crossbar output lane: AND-OR selection of the input picked by a single
// allocation row, with a conflict flag when more than one input is requested.
module xbar_onehot_sel
    import xbar_reg_nports_pkg::*;
#(
    parameter int NUM_PORT = DEF_NUM_PORT,
    parameter int WIDTH    = DEF_WIDTH
) (
    input  logic [NUM_PORT-1:0]       allocRow,
    input  logic [NUM_PORT*WIDTH-1:0] din,
    input  logic [NUM_PORT-1:0]       dinValid,
    output logic [WIDTH-1:0]          selData,
    output logic                      selValid,
    output logic                      conflict
);

    logic [WIDTH-1:0] orData;
    logic             orValid;
    logic             anySet;
    logic             oneHot;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch can be inferred.
        orData  = '0;
        orValid = 1'b0;
        for (int i = 0; i < NUM_PORT; i++) begin
            if (allocRow[i]) begin
                orData  = orData | `XBAR_LANE(din, i, WIDTH);
                orValid = orValid | dinValid[i];
            end
        end
    end

    assign anySet = (allocRow != '0);
    assign oneHot = anySet && ((allocRow & (allocRow - NUM_PORT'(1))) == '0);

    // A conflicting row drops the flit entirely rather than forwarding a merge.
    assign selData  = oneHot ? orData : '0;
    assign selValid = oneHot & orValid;
    assign conflict = anySet & ~oneHot;

endmodule

// File: rtl/xbar_reg_nports.sv
// Registered NUM_PORT x NUM_PORT crossbar with multicast, per-output conflict
// flags, a saturating conflict counter, global stall and 1 or 2 pipeline stages.
module xbar_reg_nports
    import xbar_reg_nports_pkg::*;
#(
    parameter int NUM_PORT   = DEF_NUM_PORT,
    parameter int WIDTH      = DEF_WIDTH,
    parameter int PIPE_DEPTH = 1,
    parameter int CNT_W      = DEF_CNT_W
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         stall,
    input  logic [NUM_PORT*NUM_PORT-1:0] alloc_vec,
    input  logic [NUM_PORT*WIDTH-1:0]    din,
    input  logic [NUM_PORT-1:0]          din_valid,
    output logic [NUM_PORT*WIDTH-1:0]    dout,
    output logic [NUM_PORT-1:0]          dout_valid,
    output logic [NUM_PORT-1:0]          conflict_err,
    output logic [CNT_W-1:0]             conflict_cnt,
    input  logic                         clr_err
);

    localparam int              POP_W   = $clog2(NUM_PORT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [NUM_PORT*NUM_PORT-1:0] allocS;
    logic [NUM_PORT*WIDTH-1:0]    dinS;
    logic [NUM_PORT-1:0]          validS;

    if (!pipeDepthOk(PIPE_DEPTH) || NUM_PORT < 2 || NUM_PORT > 8) begin : g_badParam
        $error("xbar_reg_nports: PIPE_DEPTH must be 1 or 2 and NUM_PORT 2..8");
    end

    if (PIPE_DEPTH == 2) begin : g_inStage
        logic [NUM_PORT*NUM_PORT-1:0] allocQ;
        logic [NUM_PORT*WIDTH-1:0]    dinQ;
        logic [NUM_PORT-1:0]          validQ;

        always_ff @(posedge clk) begin
            // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
            if (!rst_n) begin
                allocQ <= '0;
                dinQ   <= '0;
                validQ <= '0;
            end else if (!stall) begin
                allocQ <= alloc_vec;
                dinQ   <= din;
                validQ <= din_valid;
            end
        end

        assign allocS = allocQ;
        assign dinS   = dinQ;
        assign validS = validQ;
    end else begin : g_noStage
        assign allocS = alloc_vec;
        assign dinS   = din;
        assign validS = din_valid;
    end

    logic [NUM_PORT*WIDTH-1:0] selData;
    logic [NUM_PORT-1:0]       selValid;
    logic [NUM_PORT-1:0]       conflictVec;

    for (genvar o = 0; o < NUM_PORT; o++) begin : g_sel
        xbar_onehot_sel #(
            .NUM_PORT (NUM_PORT),
            .WIDTH    (WIDTH)
        ) u_sel (
            .allocRow (`XBAR_LANE(allocS, o, NUM_PORT)),
            .din      (dinS),
            .dinValid (validS),
            .selData  (`XBAR_LANE(selData, o, WIDTH)),
            .selValid (selValid[o]),
            .conflict (conflictVec[o])
        );
    end

    // A stalled cycle neither flags nor counts conflicts.
    logic [NUM_PORT-1:0]    conflictLive;
    logic [POP_W-1:0]       conflictPop;
    logic [CNT_W+POP_W-1:0] cntSum;
    logic [CNT_W-1:0]       cntNext;

    assign conflictLive = stall ? '0 : conflictVec;

    always_comb begin
        conflictPop = '0;
        for (int o = 0; o < NUM_PORT; o++) begin
            conflictPop = conflictPop + POP_W'(conflictLive[o]);
        end
        cntSum  = {{POP_W{1'b0}}, conflict_cnt} + {{CNT_W{1'b0}}, conflictPop};
        cntNext = (cntSum[CNT_W +: POP_W] != '0) ? CNT_MAX : cntSum[CNT_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dout         <= '0;
            dout_valid   <= '0;
            conflict_err <= '0;
            conflict_cnt <= '0;
        end else begin
            if (!stall) begin
                dout       <= selData;
                dout_valid <= selValid;
            end
            // Clear beats the count, but a same-cycle conflict still leaves its flag set.
            if (clr_err) begin
                conflict_err <= conflictLive;
                conflict_cnt <= '0;
            end else begin
                conflict_err <= conflict_err | conflictLive;
                conflict_cnt <= cntNext;
            end
        end
    end

endmodule

// File: tb/tb_xbar_reg_nports.sv
// Directed bench for xbar_reg_nports: a PIPE_DEPTH=1 and a PIPE_DEPTH=2/CNT_W=4
// instance share stimulus; expected outputs are queued per instance with a due cycle.
module tb_xbar_reg_nports;

    localparam int N  = 6;
    localparam int W  = 64;
    localparam int BW = N * W;

    typedef logic [BW-1:0]  bus_t;
    typedef logic [N-1:0]   vec_t;
    typedef logic [N*N-1:0] alloc_t;
    typedef struct {
        int    due;
        string tag;
        bus_t  data;
        vec_t  valid;
    } exp_t;

    logic   clk = 1'b0;
    logic   rst_n;
    logic   stall;
    logic   clrErr;
    alloc_t allocVec;
    bus_t   din;
    vec_t   dinValid;
    bus_t   doutA, doutB;
    vec_t   validA, validB, errA, errB;
    logic [7:0] cntA;
    logic [3:0] cntB;

    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    exp_t qA[$];
    exp_t qB[$];

    always #5 clk = ~clk;

    xbar_reg_nports #(.NUM_PORT(N), .WIDTH(W), .PIPE_DEPTH(1), .CNT_W(8)) dutA (
        .clk(clk), .rst_n(rst_n), .stall(stall), .alloc_vec(allocVec), .din(din),
        .din_valid(dinValid), .dout(doutA), .dout_valid(validA),
        .conflict_err(errA), .conflict_cnt(cntA), .clr_err(clrErr)
    );

    xbar_reg_nports #(.NUM_PORT(N), .WIDTH(W), .PIPE_DEPTH(2), .CNT_W(4)) dutB (
        .clk(clk), .rst_n(rst_n), .stall(stall), .alloc_vec(allocVec), .din(din),
        .din_valid(dinValid), .dout(doutB), .dout_valid(validB),
        .conflict_err(errB), .conflict_cnt(cntB), .clr_err(clrErr)
    );

    task automatic check(input string tag, input bus_t obs, input bus_t expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic alloc_t route(input alloc_t a, input int src, input int dst);
        a[dst*N + src] = 1'b1;
        return a;
    endfunction

    function automatic bus_t lane(input bus_t b, input int idx, input logic [W-1:0] v);
        b[idx*W +: W] = v;
        return b;
    endfunction

    function automatic bus_t randBus();
        bus_t b;
        for (int i = 0; i < BW / 32; i++) b[i*32 +: 32] = $urandom;
        return b;
    endfunction

    task automatic push(input bit toB, input int due, input string tag, input bus_t d, input vec_t v);
        exp_t e;
        e.due = due;
        e.tag = tag;
        e.data = d;
        e.valid = v;
        if (toB) qB.push_back(e);
        else qA.push_back(e);
    endtask

    // Advance one clock, sample 1 time unit later and retire every due expectation.
    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        cyc++;
        while (qA.size() > 0 && qA[0].due <= cyc) begin
            e = qA.pop_front();
            check({"A_", e.tag, "_dout"}, doutA, e.data);
            check({"A_", e.tag, "_valid"}, BW'(validA), BW'(e.valid));
        end
        while (qB.size() > 0 && qB[0].due <= cyc) begin
            e = qB.pop_front();
            check({"B_", e.tag, "_dout"}, doutB, e.data);
            check({"B_", e.tag, "_valid"}, BW'(validB), BW'(e.valid));
        end
    endtask

    // One unstalled cycle of stimulus; the result is due after 1 edge on A and 2 on B.
    task automatic drive(input string tag, input alloc_t a, input bus_t d, input vec_t v,
                         input bus_t expD, input vec_t expV);
        allocVec = a;
        din      = d;
        dinValid = v;
        push(1'b0, cyc + 1, tag, expD, expV);
        push(1'b1, cyc + 2, tag, expD, expV);
        tick();
    endtask

    initial begin
        alloc_t a;
        bus_t   d, e;
        int     s;
        int     aSeq[6] = '{1, 2, 3, 3, 4, 0};
        int     bSeq[6] = '{1, 2, 2, 3, 4, 0};

        // Reset overrides stall with live traffic on the inputs.
        a = '0;
        for (int o = 0; o < N; o++) a = route(a, o, o);
        rst_n = 1'b0; stall = 1'b1; clrErr = 1'b0;
        allocVec = a; din = randBus(); dinValid = '1;
        tick();
        check("A_rst_dout", doutA, '0);
        check("A_rst_valid", BW'(validA), '0);
        check("A_rst_err", BW'(errA), '0);
        check("A_rst_cnt", BW'(cntA), '0);
        check("B_rst_dout", doutB, '0);
        check("B_rst_valid", BW'(validB), '0);
        check("B_rst_err", BW'(errB), '0);
        check("B_rst_cnt", BW'(cntB), '0);
        push(1'b1, cyc + 1, "rst_stage", '0, '0);
        rst_n = 1'b1; stall = 1'b0;
        drive("idle", '0, '0, '0, '0, '0);

        // Permutation i -> (i+1)%N, one cycle wide to pin down latency.
        a = '0; d = '0; e = '0;
        for (int i = 0; i < N; i++) begin
            a = route(a, i, (i + 1) % N);
            d = lane(d, i, W'(64'hA0 + i));
            e = lane(e, (i + 1) % N, W'(64'hA0 + i));
        end
        drive("perm", a, d, '1, e, 6'h3F);
        drive("idle", '0, '0, '0, '0, '0);

        // Multicast of input 2 to outputs 0, 3 and 5.
        d = lane(randBus(), 2, 64'hDEAD_BEEF);
        a = route(route(route('0, 2, 0), 2, 3), 2, 5);
        e = lane(lane(lane('0, 0, 64'hDEAD_BEEF), 3, 64'hDEAD_BEEF), 5, 64'hDEAD_BEEF);
        drive("mcast", a, d, '1, e, 6'b101001);

        // Invalid flit still carries data; a valid one on another lane alongside it.
        d = lane(randBus(), 1, 64'h55);
        a = route(route('0, 1, 2), 4, 0);
        e = lane(lane('0, 2, 64'h55), 0, d[4*W +: W]);
        drive("nvalid", a, d, 6'b111101, e, 6'b000001);
        drive("idle", '0, '0, '0, '0, '0);

        // Conflict on output 4 for three cycles, then clear while it persists.
        a = route(route('0, 1, 4), 3, 4);
        for (int i = 0; i < 3; i++) drive("conf", a, randBus(), '1, '0, '0);
        check("A_conf_err", BW'(errA), BW'(6'b010000));
        check("A_conf_cnt", BW'(cntA), BW'(3));
        check("B_conf_err", BW'(errB), BW'(6'b010000));
        check("B_conf_cnt", BW'(cntB), BW'(2));
        clrErr = 1'b1;
        drive("confclr", a, randBus(), '1, '0, '0);
        check("A_clr_err", BW'(errA), BW'(6'b010000));
        check("A_clr_cnt", BW'(cntA), '0);
        check("B_clr_err", BW'(errB), BW'(6'b010000));
        check("B_clr_cnt", BW'(cntB), '0);
        clrErr = 1'b0;
        drive("idle", '0, '0, '0, '0, '0);
        check("A_postclr_err", BW'(errA), BW'(6'b010000));
        check("A_postclr_cnt", BW'(cntA), '0);
        check("B_postclr_cnt", BW'(cntB), BW'(1));
        clrErr = 1'b1;
        drive("idle", '0, '0, '0, '0, '0);
        check("A_clr2_err", BW'(errA), '0);
        check("A_clr2_cnt", BW'(cntA), '0);
        check("B_clr2_err", BW'(errB), '0);
        check("B_clr2_cnt", BW'(cntB), '0);
        clrErr = 1'b0;

        // Stream 1..4 into output 0; one stall while flit 3 sits in B's input stage.
        s = cyc;
        for (int k = 0; k < 6; k++) begin
            push(1'b0, s + 1 + k, "stream", lane('0, 0, W'(aSeq[k])), vec_t'(aSeq[k] != 0));
            push(1'b1, s + 2 + k, "stream", lane('0, 0, W'(bSeq[k])), vec_t'(bSeq[k] != 0));
        end
        allocVec = route('0, 0, 0); dinValid = 6'b000001;
        din = lane('0, 0, 64'd1); tick();
        din = lane('0, 0, 64'd2); tick();
        din = lane('0, 0, 64'd3); tick();
        din = lane('0, 0, 64'd4); stall = 1'b1; tick();
        stall = 1'b0; tick();
        allocVec = '0; din = '0; dinValid = '0; tick();
        tick();

        // Two conflicting outputs per cycle for ten cycles; B's 4-bit count saturates.
        a = route(route(route(route('0, 0, 1), 2, 1), 3, 2), 5, 2);
        for (int i = 1; i <= 10; i++) begin
            drive("sat", a, randBus(), '1, '0, '0);
            if (i == 8) check("B_sat_cnt8", BW'(cntB), BW'(14));
            if (i == 9) check("B_sat_cnt9", BW'(cntB), BW'(15));
        end
        check("A_sat_cnt", BW'(cntA), BW'(20));
        check("A_sat_err", BW'(errA), BW'(6'b000110));
        check("B_sat_err", BW'(errB), BW'(6'b000110));
        drive("idle", '0, '0, '0, '0, '0);
        check("B_sat_cnt11", BW'(cntB), BW'(15));
        drive("idle", '0, '0, '0, '0, '0);
        check("A_sat_hold", BW'(cntA), BW'(20));
        check("B_sat_hold", BW'(cntB), BW'(15));

        tick();
        tick();
        check("A_queue_drained", BW'(qA.size()), '0);
        check("B_queue_drained", BW'(qB.size()), '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
